// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// Latency: grant is combinational in the request cycle; response is one cycle after grant.
// Backpressure: a requester holds its request until it sees gnt; one access in flight, so grants are at least two cycles apart.
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_size_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_size_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        mem_write_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  // One request as presented by a requester.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_e state_q, state_d;
  logic   prio_q,  prio_d;   // requester that wins a tie
  logic   owner_q, owner_d;  // requester waiting for the response
  logic   we_q,    we_d;     // owner's access was a write
  logic   err_q,   err_d;    // owner's access was rejected

  req_t   m0_req, m1_req, win_req;
  logic   win_sel;
  logic   win_err;
  logic   grant_vld;

  assign m0_req = '{we: m0_we_i, size: m0_size_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1_req = '{we: m1_we_i, size: m1_size_i, addr: m1_addr_i, wdata: m1_wdata_i};

  // Pick the winner: the priority pointer breaks ties, a lone requester always wins.
  always_comb begin
    win_sel = 1'b0;
    if (m0_req_i && m1_req_i) begin
      win_sel = prio_q;
    end else if (m1_req_i) begin
      win_sel = 1'b1;
    end
    win_req   = win_sel ? m1_req : m0_req;
    win_err   = (win_req.addr >= 32'(MEM_WORDS)) || (win_req.size == SIZE_BAD);
    // No grant while in reset, so the outputs stay quiet for the whole reset pulse.
    grant_vld = !reset_i && (state_q == IDLE) && (m0_req_i || m1_req_i);
  end

  // Next state, grant strobes and the memory-side command.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    mem_write_o = 1'b0;
    mem_size_o  = SIZE_WORD;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          m0_gnt_o    = !win_sel;
          m1_gnt_o    = win_sel;
          // A rejected access must never disturb memory contents.
          mem_write_o = win_req.we && !win_err;
          mem_size_o  = win_req.size;
          mem_addr_o  = win_req.addr;
          mem_wdata_o = win_req.wdata;
          prio_d      = !win_sel;
          owner_d     = win_sel;
          we_d        = win_req.we;
          err_d       = win_err;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Requests are ignored here; the owner is answered and we go back.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response to the owner only; the other port stays at zero.
  always_comb begin
    logic        resp_vld;
    logic [31:0] resp_dat;
    resp_vld    = (state_q == RESP);
    resp_dat    = (we_q || err_q) ? 32'h0 : mem_rdata_i;

    m0_rvalid_o = resp_vld && !owner_q;
    m0_rdata_o  = m0_rvalid_o ? resp_dat : 32'h0;
    m0_err_o    = m0_rvalid_o && err_q;

    m1_rvalid_o = resp_vld && owner_q;
    m1_rdata_o  = m1_rvalid_o ? resp_dat : 32'h0;
    m1_err_o    = m1_rvalid_o && err_q;
  end

  // State registers; reset drops any pending response and points priority at requester 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases followed by randomized two-port traffic.
// A reference model predicts each grant and pushes the expected response; a monitor pops and compares.
// A behavioural memory with one-cycle read latency sits on the memory port.
module tb_dmem_arbiter;

  localparam int MW = 32;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0]       we = '0;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [1:0]       err;
  logic [1:0][31:0] rdata;
  logic             mem_write_o;
  logic [1:0]       mem_size_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dmem_arbiter #(.MEM_WORDS(MW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_size_i   (size[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m0_gnt_o    (gnt[0]),
    .m0_rvalid_o (rvalid[0]),
    .m0_rdata_o  (rdata[0]),
    .m0_err_o    (err[0]),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_size_i   (size[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
    .m1_gnt_o    (gnt[1]),
    .m1_rvalid_o (rvalid[1]),
    .m1_rdata_o  (rdata[1]),
    .m1_err_o    (err[1]),
    .mem_write_o (mem_write_o),
    .mem_size_o  (mem_size_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Byte and half writes land in the low lanes and leave the rest of the word alone.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [1:0] sz);
    case (sz)
      2'b00:   return {old[31:8], nw[7:0]};
      2'b01:   return {old[31:16], nw[15:0]};
      default: return nw;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Behavioural data memory: registered read, one-cycle latency.
  logic [31:0] mem [MW];
  always @(posedge clk_i) begin
    if (mem_write_o && mem_addr_o < MW)
      mem[int'(mem_addr_o)] <= merge(mem[int'(mem_addr_o)], mem_wdata_o, mem_size_o);
    mem_rdata_i <= (mem_addr_o < MW) ? mem[int'(mem_addr_o)] : 32'h0;
  end

  // Reference model state: contents the memory should hold, tie pointer, one access in flight.
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [MW];
  bit          busy = 1'b0;
  bit          ptr = 1'b0;

  task automatic chk_mem_idle();
    chk("idle_mem_write", 32'(mem_write_o), 32'h0);
    chk("idle_mem_size",  32'(mem_size_o), 32'h2);
    chk("idle_mem_addr",  mem_addr_o, 32'h0);
    chk("idle_mem_wdata", mem_wdata_o, 32'h0);
  endtask

  // Reference model: decide who should be granted this cycle and what they should get back.
  always @(negedge clk_i) begin
    bit          w;
    bit          e;
    logic [31:0] rd;
    if (reset_i) begin
      busy = 1'b0;
      ptr  = 1'b0;
      exp_q.delete();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk_mem_idle();
    end else if (busy || req == 2'b00) begin
      busy = 1'b0;
      chk("no_gnt", 32'(gnt), 32'h0);
      chk_mem_idle();
    end else begin
      if (req == 2'b11) w = ptr;
      else              w = req[1];
      ptr  = !w;
      busy = 1'b1;
      e    = (addr[w] >= MW) || (size[w] == 2'b11);
      chk("gnt",       32'(gnt), w ? 32'h2 : 32'h1);
      chk("mem_write", 32'(mem_write_o), 32'(we[w] && !e));
      chk("mem_size",  32'(mem_size_o), 32'(size[w]));
      chk("mem_addr",  mem_addr_o, addr[w]);
      chk("mem_wdata", mem_wdata_o, wdata[w]);
      if (we[w] && !e) ref_mem[int'(addr[w])] = merge(ref_mem[int'(addr[w])], wdata[w], size[w]);
      rd = (we[w] || e) ? 32'h0 : ref_mem[int'(addr[w])];
      exp_q.push_back('{port: int'(w), rdata: rd, err: e, cyc: cyc + 1});
    end
  end

  // Monitor: every response pulse must match the head of the expectation queue.
  always @(negedge clk_i) begin
    if (reset_i) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_rdata1", rdata[1], 32'h0);
      chk("rst_err",    32'(err), 32'h0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rvalid[k]) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].port != k) begin
            failures++;
            $display("FAIL unexpected_rvalid: port %0d pulsed rvalid, none expected (cycle %0d)", k, cyc);
          end else begin
            chk("resp_rdata", rdata[k], exp_q[0].rdata);
            chk("resp_err",   32'(err[k]), 32'(exp_q[0].err));
            void'(exp_q.pop_front());
          end
        end else begin
          chk("quiet_rdata", rdata[k], 32'h0);
          chk("quiet_err",   32'(err[k]), 32'h0);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_rvalid: port %0d got no response, expected one (cycle %0d)", exp_q[0].port, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Present one request; hold==0 means hold until granted (bounded), otherwise give up after hold cycles.
  task automatic issue(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int hold,
                       output bit g, output logic [31:0] rd, output logic re);
    int lim;
    lim = (hold == 0) ? 200 : hold;
    g  = 1'b0;
    rd = 32'h0;
    re = 1'b0;
    @(posedge clk_i); #1;
    we[k] = w; size[k] = sz; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_i);
      if (gnt[k]) begin
        g = 1'b1;
        break;
      end
    end
    @(posedge clk_i); #1;
    req[k] = 1'b0;
    if (g) begin
      @(negedge clk_i);
      rd = rdata[k];
      re = err[k];
    end else if (hold == 0) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: port %0d got no grant in %0d cycles, expected one", k, lim);
    end
  endtask

  task automatic traffic(input int k, input int n);
    bit          g;
    logic [31:0] rd;
    logic        re;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      sz = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'b11;
      a  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, MW - 1)) : 32'($urandom_range(MW, MW + 8));
      issue(k, 1'($urandom_range(0, 1)), sz, a, $urandom,
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, g, rd, re);
    end
  endtask

  task automatic hold_reads(input int k, input int n);
    bit          g;
    logic [31:0] rd;
    logic        re;
    for (int i = 0; i < n; i++) issue(k, 1'b0, 2'b10, 32'(k + 10), 32'h0, 0, g, rd, re);
  endtask

  bit          g0;
  logic [31:0] rd0;
  logic        re0;

  initial begin
    for (int i = 0; i < MW; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    size  = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Word write then read back.
    issue(0, 1'b1, 2'b10, 32'd5, 32'hDEADBEEF, 0, g0, rd0, re0);
    chk("wr5_rdata", rd0, 32'h0);
    chk("wr5_err", 32'(re0), 32'h0);
    issue(0, 1'b0, 2'b10, 32'd5, 32'h0, 0, g0, rd0, re0);
    chk("rd5_rdata", rd0, 32'hDEADBEEF);

    // Out-of-range write is rejected and leaves address 0 untouched.
    issue(1, 1'b1, 2'b10, 32'd32, 32'hCAFEF00D, 0, g0, rd0, re0);
    chk("oor_err", 32'(re0), 32'h1);
    chk("oor_rdata", rd0, 32'h0);
    issue(1, 1'b0, 2'b10, 32'd0, 32'h0, 0, g0, rd0, re0);
    chk("rd0_after_oor", rd0, 32'h0);
    chk("rd0_err", 32'(re0), 32'h0);

    // Illegal size.
    issue(0, 1'b0, 2'b11, 32'd5, 32'h0, 0, g0, rd0, re0);
    chk("badsize_err", 32'(re0), 32'h1);
    chk("badsize_rdata", rd0, 32'h0);

    // Byte write only touches the low byte.
    issue(0, 1'b1, 2'b00, 32'd3, 32'h12345678, 0, g0, rd0, re0);
    issue(0, 1'b0, 2'b10, 32'd3, 32'h0, 0, g0, rd0, re0);
    chk("byte_rdata", rd0, 32'h00000078);

    // Reset during the response cycle drops the response; priority restarts at requester 0.
    @(posedge clk_i); #1;
    we[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'd5; req[0] = 1'b1;
    g0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (gnt[0]) begin
        g0 = 1'b1;
        break;
      end
    end
    chk("rst_case_gnt", 32'(g0), 32'h1);
    @(posedge clk_i); #1;
    req[0] = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst_dropped_rvalid", 32'(rvalid[0]), 32'h0);
    @(posedge clk_i); #1;
    we = 2'b00; size[1] = 2'b10; addr[1] = 32'd1; req = 2'b11;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    @(posedge clk_i); #1;
    req[0] = 1'b0;
    g0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (gnt[1]) begin
        g0 = 1'b1;
        break;
      end
    end
    chk("rst_second_gnt", 32'(g0), 32'h1);
    @(posedge clk_i); #1;
    req[1] = 1'b0;
    repeat (2) @(negedge clk_i);

    // Both ports hold reads from reset: grants must alternate starting with port 0.
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    fork
      hold_reads(0, 4);
      hold_reads(1, 4);
      begin
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
      end
    join

    // Randomized traffic on both ports, including withdrawn requests.
    fork
      traffic(0, 150);
      traffic(1, 150);
    join

    repeat (5) @(negedge clk_i);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 32, the number of valid word addresses in the data memory.
REQ-002 The block SHALL have ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- mK_req_i  in  1  request from requester K (K = 0, 1)
- mK_we_i  in  1  1 = write, 0 = read
- mK_size_i  in  2  access size: 00 byte, 01 half, 10 word
- mK_addr_i  in  32  word address
- mK_wdata_i  in  32  write data
- mK_gnt_o  out  1  request accepted this cycle
- mK_rvalid_o  out  1  response valid
- mK_rdata_o  out  32  read data
- mK_err_o  out  1  error flag, valid with rvalid
- mem_write_o  out  1  memory write strobe
- mem_size_o  out  2  memory access size
- mem_addr_o  out  32  memory word address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, registered, one-cycle latency

Function
REQ-003 The block SHALL implement a two-state machine: IDLE and RESP.
REQ-004 In IDLE with at least one mK_req_i high, the block SHALL grant exactly one requester, assert its mK_gnt_o combinationally for one cycle, and go to RESP at the next edge.
REQ-005 Arbitration SHALL be round-robin:
- a priority pointer selects the winner when both requesters are requesting
- after any grant to requester K, the pointer SHALL point to the other requester
- when only one requester is requesting, that requester wins and the pointer still updates.
REQ-006 In the grant cycle, mem_size_o, mem_addr_o and mem_wdata_o SHALL be driven from the granted requester.
REQ-007 In the grant cycle, mem_write_o SHALL equal the granted mK_we_i, unless the access is erroneous; then mem_write_o SHALL be 0.
REQ-008 Outside a grant cycle, mem_write_o, mem_addr_o and mem_wdata_o SHALL be 0, and mem_size_o SHALL be 2'b10.
REQ-009 An access SHALL be erroneous when mK_addr_i >= MEM_WORDS or mK_size_i = 2'b11.
REQ-010 On the IDLE->RESP edge, the block SHALL register the owner (0/1), the access type and the error flag.
REQ-011 In RESP, the block SHALL assert the owner's mK_rvalid_o for exactly one cycle, then return to IDLE.
REQ-012 In RESP, the owner's mK_rdata_o SHALL be:
- mem_rdata_i for a non-erroneous read
- 0 for a write or an erroneous access.
REQ-013 In RESP, the owner's mK_err_o SHALL equal the registered error flag.
REQ-014 In RESP, no grant SHALL be issued and requests SHALL be ignored.
- Minimum spacing between grants is two cycles.
- Grant-to-rvalid latency is exactly one cycle.
REQ-015 A requester SHALL hold mK_req_i and all its fields stable until mK_gnt_o is seen. A request withdrawn before grant SHALL be dropped with no response.
REQ-016 The non-owner's mK_rvalid_o, mK_rdata_o and mK_err_o SHALL be 0 in every cycle.
REQ-017 A requester re-asserting mK_req_i in its own RESP cycle SHALL be eligible for arbitration in the following IDLE cycle under the updated pointer.

Reset
REQ-018 While reset_i is high, the block SHALL be in IDLE with the priority pointer on requester 0, and all gnt, rvalid, rdata and err outputs SHALL be 0.
REQ-019 Assertion of reset_i in RESP SHALL drop the pending response with no rvalid pulse, and the block SHALL be in IDLE after deassertion.
REQ-020 Memory outputs SHALL take their REQ-008 idle values during reset.

Verification
REQ-021 Single write then read:
- m0 write addr 5, size 10, wdata 0xDEADBEEF -> m0_gnt_o in cycle N; mem_write_o=1 and mem_addr_o=5 in N; m0_rvalid_o=1 in N+1 with rdata 0 and err 0.
- m0 read addr 5 -> m0_rdata_o=0xDEADBEEF one cycle after grant.
REQ-022 Contention:
- m0 and m1 both hold read requests from reset -> grants alternate m0, m1, m0, m1 on cycles N, N+2, N+4, N+6.
- each grant is followed by rvalid only on the granted port.
REQ-023 Error, address out of range: m1 write addr 32 (MEM_WORDS=32) -> m1_gnt_o=1 with mem_write_o=0; next cycle m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0; a later read of addr 0 returns its prior value.
REQ-024 Error, bad size: m0 read with size 11 -> m0_rvalid_o=1, m0_err_o=1, m0_rdata_o=0.
REQ-025 Reset mid-operation: reset_i pulsed in the RESP cycle of an m0 read -> no m0_rvalid_o pulse; after deassertion, m0 and m1 requesting together -> m0 granted first.
REQ-026 Byte write: m0 write addr 3, size 00, wdata 0x12345678 -> mem_size_o=00 in the grant cycle; a subsequent word read of addr 3 returns 0x00000078.
